gated_regfile: RTL and testbench

- Parametrised register file: one write port, two read ports, registered reads.
- Each read output is AND-gated by its read enable, so a disabled port drives all-zero.
- Built-in clear sequencer zeroes every entry, one per cycle.
- Sits in the Regfile area and feeds the decode-stage operand path of the RISC-V core.

---
 rtl/regfile_pkg.sv | 16 +
 rtl/and_gate_n.sv | 15 +
 rtl/gated_regfile.sv | 137 +++++++++++++
 tb/tb_gated_regfile.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared definitions for the gated register file.
//   - Default geometry constants (DATA_W / DEPTH / ADDR_W).
//   - Clear-sequencer state encoding.
package regfile_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 5;
  localparam int DEF_DEPTH  = 32;

  // Clear sequencer: IDLE serves user traffic, CLEAR walks the array zeroing it.
  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

endpackage

// File: rtl/and_gate_n.sv
// Vector AND with a single-bit enable: y = a when en = 1, otherwise all zero.
//   a   in  DATA_W  data to gate
//   en  in  1       enable
//   y   out DATA_W  gated data
module and_gate_n #(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] a,
  input  logic              en,
  output logic [DATA_W-1:0] y
);

  assign y = a & {DATA_W{en}};

endmodule

// File: rtl/gated_regfile.sv
// Register file with one write port and two registered, enable-gated read ports,
// plus a clear sequencer that zeroes one entry per cycle.
//
// Ports:
//   clk             in   rising-edge clock
//   rst             in   asynchronous active-high reset (clears array, outputs, FSM)
//   we/waddr/wdata  in   write port; out-of-range or zero-register writes dropped
//   re1/raddr1      in   read port 1 request
//   rdata1          out  read port 1 data, one cycle after the request
//   re2/raddr2      in   read port 2 request
//   rdata2          out  read port 2 data, one cycle after the request
//   clr             in   one-cycle pulse that starts the clear sequence
//   busy            out  high while the clear sequence runs (exactly DEPTH cycles)
//
// Read timing: there is no handshake. A request presented on reN/raddrN at a
// rising edge is answered on rdataN right after that edge; a disabled port, an
// out-of-range or zero-register address, or any edge taken while clearing
// yields all-zero data.
//
// Build option: define REGFILE_BYPASS_EN to forward same-cycle write data to a
// read of the same writable address; without it such a read sees the old value.
module gated_regfile
  import regfile_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int DEPTH    = DEF_DEPTH,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int ZERO_REG = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re1,
  input  logic [ADDR_W-1:0] raddr1,
  output logic [DATA_W-1:0] rdata1,
  input  logic              re2,
  input  logic [ADDR_W-1:0] raddr2,
  output logic [DATA_W-1:0] rdata2,
  input  logic              clr,
  output logic              busy
);

  // One extra bit so DEPTH == 2**ADDR_W is representable in the range compare.
  localparam logic [ADDR_W:0]   DEPTH_X = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(DEPTH - 1);

  state_t              state;
  logic [ADDR_W-1:0]   cnt;
  logic [DATA_W-1:0]   mem [DEPTH];

  logic                clearing;
  logic                wr_ok;
  logic [DATA_W-1:0]   rd1_raw, rd2_raw;
  logic [DATA_W-1:0]   rd1_src, rd2_src;
  logic [DATA_W-1:0]   rd1_g, rd2_g;
  logic                en1, en2;

  // An address is live when it is inside the array and is not the hardwired zero.
  function automatic logic live_addr(input logic [ADDR_W-1:0] a);
    return ({1'b0, a} < DEPTH_X) && !((ZERO_REG != 0) && (a == '0));
  endfunction

  assign clearing = (state == CLEAR);
  assign busy     = clearing;
  assign wr_ok    = we && !clearing && live_addr(waddr);

  always_comb begin
    rd1_raw = '0;
    rd2_raw = '0;
    if (live_addr(raddr1)) rd1_raw = mem[raddr1];
    if (live_addr(raddr2)) rd2_raw = mem[raddr2];
  end

`ifdef REGFILE_BYPASS_EN
  // wr_ok already excludes zero-register, out-of-range and clearing cases.
  assign rd1_src = (wr_ok && (raddr1 == waddr)) ? wdata : rd1_raw;
  assign rd2_src = (wr_ok && (raddr2 == waddr)) ? wdata : rd2_raw;
`else
  assign rd1_src = rd1_raw;
  assign rd2_src = rd2_raw;
`endif

  // Clearing overrides the read enables so both ports read zero during the sweep.
  assign en1 = re1 && !clearing;
  assign en2 = re2 && !clearing;

  and_gate_n #(.DATA_W(DATA_W)) u_gate1 (.a(rd1_src), .en(en1), .y(rd1_g));
  and_gate_n #(.DATA_W(DATA_W)) u_gate2 (.a(rd2_src), .en(en2), .y(rd2_g));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata1 <= '0;
      rdata2 <= '0;
    end else begin
      rdata1 <= rd1_g;
      rdata2 <= rd2_g;
    end
  end

  // Array and clear sequencer share one process: user writes only happen in
  // IDLE and sweep writes only in CLEAR, so the two never collide.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      case (state)
        IDLE: begin
          // A write in the same cycle as clr still lands; the sweep erases it later.
          if (wr_ok) mem[waddr] <= wdata;
          if (clr) begin
            state <= CLEAR;
            cnt   <= '0;
          end
        end
        CLEAR: begin
          mem[cnt] <= '0;
          // Terminate on DEPTH-1 rather than counter wrap so any DEPTH works.
          if (cnt == LAST) begin
            state <= IDLE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + ADDR_W'(1);
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gated_regfile.sv
// Bench for gated_regfile: instance 0 uses defaults (DEPTH 32), instance 1 uses
// DEPTH 20. Drivers push expected read data into per-port queues; a monitor pops
// and compares one cycle after each issued read.
module tb_gated_regfile;

  logic        clk;
  logic        rst;
  logic [1:0]  we, re1, re2, clr, busy;
  logic [4:0]  waddr  [2];
  logic [31:0] wdata  [2];
  logic [4:0]  raddr1 [2];
  logic [4:0]  raddr2 [2];
  logic [31:0] rdata1 [2];
  logic [31:0] rdata2 [2];

  logic [1:0]  chk1_req, chk2_req, chk1_q, chk2_q;

  logic [31:0] exp_q0[$];
  logic [31:0] exp_q1[$];
  logic [31:0] exp_q2[$];
  logic [31:0] exp_q3[$];

  int n_pass  = 0;
  int n_total = 0;

`ifdef REGFILE_BYPASS_EN
  localparam logic [31:0] EXP_SAME = 32'hA5A5_A5A5;
`else
  localparam logic [31:0] EXP_SAME = 32'h0000_0001;
`endif

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  gated_regfile u0 (
    .clk(clk), .rst(rst), .we(we[0]), .waddr(waddr[0]), .wdata(wdata[0]),
    .re1(re1[0]), .raddr1(raddr1[0]), .rdata1(rdata1[0]),
    .re2(re2[0]), .raddr2(raddr2[0]), .rdata2(rdata2[0]),
    .clr(clr[0]), .busy(busy[0])
  );

  gated_regfile #(.DEPTH(20)) u1 (
    .clk(clk), .rst(rst), .we(we[1]), .waddr(waddr[1]), .wdata(wdata[1]),
    .re1(re1[1]), .raddr1(raddr1[1]), .rdata1(rdata1[1]),
    .re2(re2[1]), .raddr2(raddr2[1]), .rdata2(rdata2[1]),
    .clr(clr[1]), .busy(busy[1])
  );

  // ---------------- checking ----------------
  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
  endtask

  function automatic string port_name(input int q);
    case (q)
      0:       return "u0.rdata1";
      1:       return "u0.rdata2";
      2:       return "u1.rdata1";
      default: return "u1.rdata2";
    endcase
  endfunction

  task automatic push_exp(input int q, input logic [31:0] e);
    case (q)
      0:       exp_q0.push_back(e);
      1:       exp_q1.push_back(e);
      2:       exp_q2.push_back(e);
      default: exp_q3.push_back(e);
    endcase
  endtask

  task automatic pop_check(input int q, input logic [31:0] act);
    logic [31:0] e;
    int sz;
    case (q)
      0:       sz = exp_q0.size();
      1:       sz = exp_q1.size();
      2:       sz = exp_q2.size();
      default: sz = exp_q3.size();
    endcase
    if (sz == 0) begin
      n_total++;
      $display("FAIL %s underflow: got 0x%08h expected <none>", port_name(q), act);
      return;
    end
    case (q)
      0:       e = exp_q0.pop_front();
      1:       e = exp_q1.pop_front();
      2:       e = exp_q2.pop_front();
      default: e = exp_q3.pop_front();
    endcase
    check(port_name(q), act, e);
  endtask

  // Read requests become due one edge after they are issued.
  always @(posedge clk) begin
    chk1_q <= chk1_req;
    chk2_q <= chk2_req;
  end

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (chk1_q[d]) pop_check(2*d,     rdata1[d]);
      if (chk2_q[d]) pop_check(2*d + 1, rdata2[d]);
    end
  end

  // ---------------- drivers (called at a falling edge) ----------------
  task automatic drive(input int d,
                       input logic w, input logic [4:0] wa, input logic [31:0] wd,
                       input logic r1, input logic [4:0] a1, input logic k1, input logic [31:0] e1,
                       input logic r2, input logic [4:0] a2, input logic k2, input logic [31:0] e2,
                       input logic c);
    we[d] = w;  waddr[d] = wa;  wdata[d] = wd;
    re1[d] = r1; raddr1[d] = a1; chk1_req[d] = k1;
    re2[d] = r2; raddr2[d] = a2; chk2_req[d] = k2;
    clr[d] = c;
    if (k1) push_exp(2*d, e1);
    if (k2) push_exp(2*d + 1, e2);
    @(negedge clk);
    we[d] = 1'b0; re1[d] = 1'b0; re2[d] = 1'b0; clr[d] = 1'b0;
    chk1_req[d] = 1'b0; chk2_req[d] = 1'b0;
  endtask

  task automatic wr(input int d, input logic [4:0] a, input logic [31:0] v);
    drive(d, 1'b1, a, v, 1'b0, 5'd0, 1'b0, 32'd0, 1'b0, 5'd0, 1'b0, 32'd0, 1'b0);
  endtask

  task automatic rd1(input int d, input logic [4:0] a, input logic [31:0] e);
    drive(d, 1'b0, 5'd0, 32'd0, 1'b1, a, 1'b1, e, 1'b0, 5'd0, 1'b0, 32'd0, 1'b0);
  endtask

  task automatic rd2(input int d, input logic [4:0] a, input logic [31:0] e);
    drive(d, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b0, 32'd0, 1'b1, a, 1'b1, e, 1'b0);
  endtask

  task automatic idle(input int d);
    drive(d, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b0, 32'd0, 1'b0, 5'd0, 1'b0, 32'd0, 1'b0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n;
    logic [4:0] wa;

    rst = 1'b1;
    we = '0; re1 = '0; re2 = '0; clr = '0;
    chk1_req = '0; chk2_req = '0;
    for (int d = 0; d < 2; d++) begin
      waddr[d] = '0; wdata[d] = '0; raddr1[d] = '0; raddr2[d] = '0;
    end
    repeat (3) @(negedge clk);
    check("reset busy u0", 32'(busy[0]), 32'd0);
    check("reset rdata1 u0", rdata1[0], 32'd0);
    check("reset rdata2 u0", rdata2[0], 32'd0);
    check("reset busy u1", 32'(busy[1]), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Basic write/read and enable gating.
    wr(0, 5'd5, 32'hDEAD_BEEF);
    rd1(0, 5'd5, 32'hDEAD_BEEF);
    drive(0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd5, 1'b1, 32'd0, 1'b1, 5'd5, 1'b1, 32'hDEAD_BEEF, 1'b0);

    // Hardwired zero register.
    wr(0, 5'd0, 32'h1234_5678);
    drive(0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 1'b1, 32'd0, 1'b1, 5'd0, 1'b1, 32'd0, 1'b0);

    // Same-cycle write and read of one address.
    wr(0, 5'd7, 32'h0000_0001);
    drive(0, 1'b1, 5'd7, 32'hA5A5_A5A5, 1'b1, 5'd7, 1'b1, EXP_SAME, 1'b1, 5'd7, 1'b1, EXP_SAME, 1'b0);
    rd2(0, 5'd7, 32'hA5A5_A5A5);

    // Fill every entry with its index; entry 0 stays zero.
    for (int a = 0; a < 32; a++) wr(0, 5'(a), 32'(a));
    rd1(0, 5'd31, 32'd31);
    rd2(0, 5'd0, 32'd0);

    // clr together with a write (committed, later swept) and normal reads.
    drive(0, 1'b1, 5'd9, 32'h0000_BEEF, 1'b1, 5'd31, 1'b1, 32'd31, 1'b1, 5'd17, 1'b1, 32'd17, 1'b1);

    // During the sweep: reads forced to zero, writes to already-cleared entries
    // must be dropped, and a second clr at count 10 must not restart.
    n = 0;
    while (busy[0] && n < 100) begin
      wa = (n == 0) ? 5'd0 : 5'(n - 1);
      drive(0, 1'b1, wa, 32'hFFFF_FFFF, 1'b1, wa, 1'b1, 32'd0, 1'b0, 5'd0, 1'b0, 32'd0, (n == 10));
      n++;
    end
    check("u0 busy cycles", 32'(n), 32'd32);
    for (int a = 0; a < 32; a++)
      drive(0, 1'b0, 5'd0, 32'd0, 1'b1, 5'(a), 1'b1, 32'd0, 1'b1, 5'(31 - a), 1'b1, 32'd0, 1'b0);

    // Reset in the middle of a sweep.
    wr(0, 5'd25, 32'h0000_0055);
    wr(0, 5'd3, 32'h0000_0033);
    rd1(0, 5'd25, 32'h0000_0055);
    drive(0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b0, 32'd0, 1'b0, 5'd0, 1'b0, 32'd0, 1'b1);
    n = 0;
    while (busy[0] && n < 10) begin
      idle(0);
      n++;
    end
    check("u0 busy before mid-clear reset", 32'(busy[0]), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("mid-clear reset busy", 32'(busy[0]), 32'd0);
    check("mid-clear reset rdata1", rdata1[0], 32'd0);
    check("mid-clear reset rdata2", rdata2[0], 32'd0);
    @(negedge clk);
    rst = 1'b0;
    idle(0);
    check("u0 busy after reset", 32'(busy[0]), 32'd0);
    drive(0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd25, 1'b1, 32'd0, 1'b1, 5'd3, 1'b1, 32'd0, 1'b0);
    rd1(0, 5'd5, 32'd0);

    // DEPTH 20 instance: range limits and a short sweep.
    wr(1, 5'd25, 32'h0000_0077);
    rd1(1, 5'd25, 32'd0);
    wr(1, 5'd19, 32'h0000_0019);
    rd1(1, 5'd19, 32'h0000_0019);
    wr(1, 5'd20, 32'h0000_0020);
    rd2(1, 5'd20, 32'd0);
    drive(1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b0, 32'd0, 1'b0, 5'd0, 1'b0, 32'd0, 1'b1);
    n = 0;
    while (busy[1] && n < 100) begin
      idle(1);
      n++;
    end
    check("u1 busy cycles", 32'(n), 32'd20);
    idle(1);
    check("u1 busy after sweep", 32'(busy[1]), 32'd0);
    rd1(1, 5'd19, 32'd0);

    repeat (3) @(negedge clk);
    check("expected queues drained",
          32'(exp_q0.size() + exp_q1.size() + exp_q2.size() + exp_q3.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
